yrv_ser_rx: RTL and testbench

// - Serial 8N1 receiver: far end of the yrv_mcu ser_txd line.
// - Recovers bytes from the MCU transmit stream and presents them on a valid/ready port.
// - Used by the tb_yrv_mcu bench as a console monitor, and on boards as a loopback/host-side receiver.
// - Flags framing errors and overruns in sticky bits.

---
 rtl/yrv_ser_pkg.sv | 7 +
 rtl/yrv_sync2.sv | 21 ++
 rtl/yrv_ser_rx.sv | 135 +++++++++++++
 tb/tb_yrv_ser_rx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/yrv_ser_pkg.sv
// rtl/yrv_ser_pkg.sv - shared types and constants for the yrv serial blocks
package yrv_ser_pkg;
  localparam int SER_DATA_BITS          = 8;
  localparam int SER_BIT_CYCLES_DEFAULT = 434;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} ser_rx_state_t;
endpackage

// File: rtl/yrv_sync2.sv
// rtl/yrv_sync2.sv - two-flop synchronizer with a parameterized reset value
module yrv_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/yrv_ser_rx.sv
// rtl/yrv_ser_rx.sv - 8N1 serial receiver with valid/ready output and sticky error flags
module yrv_ser_rx
  import yrv_ser_pkg::*;
#(
  parameter int BIT_CYCLES = SER_BIT_CYCLES_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ser_rxd_in,
  input  logic                     rx_ready,
  input  logic                     err_clr,
  output logic [SER_DATA_BITS-1:0] rx_data,
  output logic                     rx_valid,
  output logic                     frame_err,
  output logic                     overrun,
  output logic                     busy
);
  localparam int            CW   = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] HALF = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BIT_CYCLES - 1);
  localparam logic [2:0]    LAST = 3'(SER_DATA_BITS - 1);

  ser_rx_state_t            state, state_n;
  logic [CW-1:0]            cnt, cnt_n;
  logic [2:0]               bit_idx, bit_idx_n;
  logic [SER_DATA_BITS-1:0] shreg, shreg_n;
  logic                     rxd_s;
  logic                     tick;
  logic                     deliver;
  logic                     ferr_set;

  yrv_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (reset),
    .d   (ser_rxd_in),
    .q   (rxd_s)
  );

  assign tick = (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      busy    <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    deliver   = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE: begin
        if (!rxd_s) begin
          state_n = START;
          cnt_n   = HALF;
        end
      end
      START: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else if (!rxd_s) begin
          state_n   = DATA;
          cnt_n     = FULL;
          bit_idx_n = '0;
        end else begin
          state_n = IDLE;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else begin
          shreg_n   = {rxd_s, shreg[SER_DATA_BITS-1:1]};
          cnt_n     = FULL;
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == LAST) state_n = STOP;
        end
      end
      STOP: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else if (rxd_s) begin
          deliver = 1'b1;
          state_n = IDLE;
        end else begin
          ferr_set = 1'b1;
          state_n  = WAIT_HI;
        end
      end
      WAIT_HI: begin
        // a held break must go high before another start can be seen
        if (rxd_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (err_clr) begin
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end
      if (ferr_set) frame_err <= 1'b1;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_yrv_ser_rx.sv
// tb/tb_yrv_ser_rx.sv - self-checking bench for yrv_ser_rx
module tb_yrv_ser_rx;
  localparam int BC    = 16;
  localparam int HALF  = BC / 2 - 1;
  localparam int LIMIT = 9 * BC + HALF + 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ser_rxd_in = 1'b1;
  logic       rx_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  int total = 0;
  int bad = 0;
  int vcount = 0;
  logic [7:0] got[$];

  yrv_ser_rx #(.BIT_CYCLES(BC)) dut (
    .clk        (clk),
    .reset      (reset),
    .ser_rxd_in (ser_rxd_in),
    .rx_ready   (rx_ready),
    .err_clr    (err_clr),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rx_valid) vcount <= vcount + 1;
    if (rx_valid && rx_ready) got.push_back(rx_data);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 8N1 frame, LSB first; line is left at the stop-bit level
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ser_rxd_in = bits[i];
      idle(BC);
    end
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t tbl[6];

  // frame-level reference model of the holding register and flags
  logic       m_valid, m_ferr, m_ovr;
  logic [7:0] m_data;

  initial begin
    int lat;
    int n0, q0;
    logic busy_seen;
    logic [7:0] b;
    logic st;

    tbl[0] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    tbl[2] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0};
    tbl[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0};
    tbl[4] = '{8'hC3, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[5] = '{8'h69, 1'b1, 1'b1, 8'h69, 1'b0};

    idle(3);
    reset = 1'b0;
    idle(3);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_busy", busy, 0);

    // 0xA5 with latency bound from the start edge
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (!rx_valid && lat < LIMIT + 40) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    chk("a5_valid", rx_valid, 1);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_ferr", frame_err, 0);
    chk("a5_latency_within", (lat <= LIMIT), 1);
    chk("a5_latency_not_early", (lat >= 9 * BC), 1);
    pulse_ready();
    chk("a5_consumed", rx_valid, 0);

    // short low glitch
    busy_seen = 1'b0;
    ser_rxd_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      busy_seen |= busy;
    end
    ser_rxd_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      busy_seen |= busy;
    end
    chk("glitch_busy_pulse", busy_seen, 1);
    chk("glitch_idle", busy, 0);
    chk("glitch_no_valid", rx_valid, 0);
    chk("glitch_no_ferr", frame_err, 0);
    chk("glitch_no_ovr", overrun, 0);

    // framing error with held break
    send_frame(8'h3C, 1'b0);
    idle(64);
    chk("break_ferr", frame_err, 1);
    chk("break_no_valid", rx_valid, 0);
    chk("break_wait_hi", busy, 1);
    ser_rxd_in = 1'b1;
    idle(20);
    chk("break_released", busy, 0);
    send_frame(8'h81, 1'b1);
    chk("after_break_valid", rx_valid, 1);
    chk("after_break_data", rx_data, 8'h81);
    pulse_ready();
    pulse_clr();
    chk("ferr_cleared", frame_err, 0);

    // overrun
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(4);
    chk("ovr_data_kept", rx_data, 8'h11);
    chk("ovr_flag", overrun, 1);
    chk("ovr_valid", rx_valid, 1);
    pulse_clr();
    chk("ovr_cleared", overrun, 0);
    chk("ovr_data_still", rx_data, 8'h11);
    pulse_ready();

    // back-to-back with consumer always ready
    rx_ready = 1'b1;
    n0 = vcount;
    q0 = got.size();
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    idle(5);
    rx_ready = 1'b0;
    chk("b2b_pulses", vcount - n0, 2);
    chk("b2b_first", (got.size() > q0) ? got[q0] : 8'hxx, 8'h55);
    chk("b2b_second", (got.size() > q0 + 1) ? got[q0 + 1] : 8'hxx, 8'hAA);
    chk("b2b_flags", {frame_err, overrun}, 0);

    // reset during data bit 3
    send_frame(8'h5A, 1'b1);
    chk("pre_reset_valid", rx_valid, 1);
    ser_rxd_in = 1'b0;
    idle(BC);
    for (int i = 0; i < 3; i++) begin
      ser_rxd_in = 1'(8'h3C >> i);
      idle(BC);
    end
    ser_rxd_in = 1'b1;
    idle(BC / 2);
    chk("pre_reset_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_outputs", {rx_valid, rx_data, frame_err, overrun, busy}, 0);
    idle(3);
    reset = 1'b0;
    idle(5);
    send_frame(8'h7E, 1'b1);
    chk("post_reset_valid", rx_valid, 1);
    chk("post_reset_data", rx_data, 8'h7E);
    pulse_ready();

    // table-driven single frames
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].d, tbl[i].stop);
      if (!tbl[i].stop) begin
        ser_rxd_in = 1'b1;
        idle(20);
      end
      chk($sformatf("tbl%0d_valid", i), rx_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) chk($sformatf("tbl%0d_data", i), rx_data, tbl[i].exp_data);
      chk($sformatf("tbl%0d_ferr", i), frame_err, tbl[i].exp_ferr);
      pulse_ready();
      pulse_clr();
      idle(2);
    end

    // randomized frames against the frame-level model
    m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_data = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        pulse_ready();
        m_valid = 1'b0;
      end
      if ($urandom_range(0, 4) == 0) begin
        pulse_clr();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
      end
      b  = 8'($urandom);
      st = ($urandom_range(0, 4) != 0);
      send_frame(b, st);
      if (st) begin
        if (!m_valid) begin
          m_valid = 1'b1;
          m_data  = b;
        end else begin
          m_ovr = 1'b1;
        end
      end else begin
        m_ferr = 1'b1;
        ser_rxd_in = 1'b1;
        idle(20);
      end
      idle(2);
      chk($sformatf("rnd%0d_valid", i), rx_valid, m_valid);
      if (m_valid) chk($sformatf("rnd%0d_data", i), rx_data, m_data);
      chk($sformatf("rnd%0d_ferr", i), frame_err, m_ferr);
      chk($sformatf("rnd%0d_ovr", i), overrun, m_ovr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
